// File: rtl/fc_result_writer_pkg.sv
// fc_result_writer_pkg: shared FC output-path widths and the result writer FSM encoding
package fc_result_writer_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } fc_wr_state_t;
endpackage

// File: rtl/fc_argmax.sv
// fc_argmax: running signed argmax over a stream of indexed values; ties keep the earliest index
module fc_argmax #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [9:0]        index,
    input  logic [DATA_W-1:0] value,
    input  logic              clear,
    output logic [9:0]        max_index,
    output logic [DATA_W-1:0] max_value
);
    localparam logic [DATA_W-1:0] MIN_VALUE = {1'b1, {(DATA_W-1){1'b0}}};
    logic [9:0]               best_index;
    logic signed [DATA_W-1:0] best_value;
    logic                     take;
    // outputs fold in the word being accepted so the owner can latch the final result on the last write
    assign take      = valid && $signed(value) > best_value;
    assign max_index = take ? index : best_index;
    assign max_value = take ? value : best_value;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_index <= '0;
            best_value <= MIN_VALUE;
        end else if (clear) begin
            best_index <= '0;
            best_value <= MIN_VALUE;
        end else if (take) begin
            best_index <= index;
            best_value <= value;
        end
    end
endmodule

// File: rtl/fc_result_writer.sv
// fc_result_writer: snapshots an FC layer output vector, streams it to memory one word per
// accepted cycle and publishes the argmax of the completed vector.
module fc_result_writer #(
    parameter int NUM_NODES = 84,
    parameter int DATA_W    = fc_result_writer_pkg::DATA_W,
    parameter int ADDR_W    = fc_result_writer_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [NUM_NODES*DATA_W-1:0] nodes_in,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    input  logic                        mem_ready,
    output logic                        busy,
    output logic                        finished,
    output logic [9:0]                  max_index,
    output logic [DATA_W-1:0]           max_value
);
    import fc_result_writer_pkg::*;
    localparam int IDX_W = NUM_NODES > 1 ? $clog2(NUM_NODES) : 1;
    fc_wr_state_t      state;
    logic [IDX_W-1:0]  count;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] snap [NUM_NODES];
    logic              launch;
    logic              accept;
    logic              last;
    logic [9:0]        run_index;
    logic [DATA_W-1:0] run_value;
    assign launch   = state == IDLE && start;
    assign accept   = mem_we && mem_ready;
    assign last     = count == IDX_W'(NUM_NODES - 1);
    assign mem_we   = state == WRITE;
    assign busy     = mem_we;
    assign finished = state == DONE;
    // address/data are pure functions of held state, so they cannot move during a stall
    assign mem_addr = mem_we ? base_q + ADDR_W'(count) : '0;
    assign mem_data = mem_we ? snap[count] : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            base_q    <= '0;
            max_index <= '0;
            max_value <= '0;
        end else if (launch) begin
            state  <= WRITE;
            count  <= '0;
            base_q <= base_addr;
        end else if (accept) begin
            count <= count + IDX_W'(1);
            if (last) begin
                state     <= DONE;
                max_index <= run_index;
                max_value <= run_value;
            end
        end else if (finished) begin
            state <= IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (launch) begin
            for (int k = 0; k < NUM_NODES; k++) snap[k] <= nodes_in[k*DATA_W +: DATA_W];
        end
    end
    fc_argmax #(.DATA_W(DATA_W)) u_argmax (
        .clk      (clk),
        .reset    (reset),
        .valid    (accept),
        .index    (10'(count)),
        .value    (mem_data),
        .clear    (launch),
        .max_index(run_index),
        .max_value(run_value)
    );
endmodule

// File: doc/fc_result_writer.md
FC_RESULT_WRITER -- requirements
Module: fc_result_writer

Interface
REQ-001 Parameter NUM_NODES, default 84, number of 16-bit output nodes written per transfer (legal range 1..1024).
REQ-002 Parameter DATA_W, default 16, node word width in signed fixed point.
REQ-003 Parameter ADDR_W, default 14, memory word-address width (16384-word memory).
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port start, input, 1, request to write one output vector; sampled only in IDLE.
REQ-007 Port base_addr, input, ADDR_W, first memory address of the vector; sampled with start.
REQ-008 Port nodes_in, input, NUM_NODES*DATA_W, flattened layer outputs; node k occupies bits [k*DATA_W +: DATA_W]; sampled with start.
REQ-009 Port mem_we, output, 1, write strobe to memory.
REQ-010 Port mem_addr, output, ADDR_W, write address.
REQ-011 Port mem_data, output, DATA_W, write data.
REQ-012 Port mem_ready, input, 1, memory accepts the presented write when mem_we and mem_ready are both high at a rising edge.
REQ-013 Port busy, output, 1, high from the cycle after accepted start until finished.
REQ-014 Port finished, output, 1, one-cycle pulse after the last word is accepted.
REQ-015 Port max_index, output, 10, index of the largest node of the last completed transfer.
REQ-016 Port max_value, output, DATA_W, value of that node.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, DONE.
REQ-018 In IDLE with start high, the block SHALL snapshot nodes_in and base_addr into internal registers, clear the word counter, and enter WRITE next cycle.
REQ-019 In WRITE, mem_we SHALL be 1, mem_addr SHALL equal (base + count) mod 2^ADDR_W, and mem_data SHALL equal snapshot node[count].
REQ-020 mem_addr/mem_data SHALL stay stable while mem_we is high and mem_ready is low.
REQ-021 On each accepted write, count SHALL increment by one; after acceptance of node NUM_NODES-1, the FSM SHALL enter DONE.
REQ-022 Peak throughput SHALL be one word per cycle; with mem_ready tied high, finished SHALL assert exactly NUM_NODES+1 cycles after the start cycle.
REQ-023 DONE SHALL last one cycle with finished=1, busy=0, mem_we=0, then return to IDLE.
REQ-024 Running argmax SHALL update on each accepted write using signed comparison; ties keep the lower index; max_index/max_value SHALL update visibly only in DONE and hold until the next DONE.
REQ-025 start asserted outside IDLE SHALL be ignored; start held high SHALL launch a new transfer from IDLE after every DONE.
REQ-026 Changes on nodes_in or base_addr after the start cycle SHALL NOT affect the transfer in progress.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_W without error indication.

Reset
REQ-028 reset low SHALL immediately force state IDLE, mem_we=0, busy=0, finished=0, mem_addr=0, mem_data=0, max_index=0, max_value=0, count=0.
REQ-029 reset asserted mid-transfer SHALL abort it; no further writes occur and no finished pulse is produced.
REQ-030 The first start is honoured on the first rising edge after reset deasserts.

Structure
REQ-031 The shared FC package SHALL hold DATA_W, ADDR_W, and the FSM state enum (typedef fc_wr_state_t).
REQ-032 The argmax tracker SHALL be a separate sub-module fc_argmax (inputs: valid, index, value, clear; outputs: max_index, max_value).
REQ-033 The node snapshot SHALL be a register array; no memory macro is used.

Verification
REQ-034 NUM_NODES=84, base=10204, mem_ready=1, nodes k*3 -> mem[10204..10287]=0,3,...,249; finished at cycle 85 after start; max_index=83.
REQ-035 mem_ready toggling 1,0,0,1,... -> no word lost/duplicated; addr/data stable during stalls; finished only after 84th acceptance.
REQ-036 NUM_NODES=10, base=16380 -> writes to 16380..16383 then 0..5.
REQ-037 nodes with -5 at k=2, 7 at k=4 and k=8, rest -32768 -> max_index=4, max_value=7.
REQ-038 reset low after the 20th accepted write -> mem_we falls asynchronously; no finished; next start writes all nodes from base.
REQ-039 start re-pulsed during WRITE and nodes_in changed mid-transfer -> ignored; memory holds the original snapshot.
